run_sequencer: RTL and testbench
================================

# run_sequencer

Host-side launch controller that sits directly upstream of the processor core and drives the core's `reset` and `req` inputs. It consumes the core's `done` output. On each host `start`, it resets the core, issues a one-cycle request, and counts execution cycles until the core signals completion. It reports the result back to the bench/host, with an optional watchdog that aborts runs that never finish.

## Interface
- `CW`, 16: cycle-counter width; `cycle_count` saturates at 2^CW-1.
- `RST_CYCLES`, 2: number of cycles `core_reset` is held high per launch; legal values are 1 to 15.
- `TIMEOUT`, 4096: watchdog limit in counted cycles; must be ≤ 2^CW-1. Only used with `RUN_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single system clock, shared with the core.
- `reset`  in  1  asynchronous, active-high block reset.
- `start`  in  1  host launch pulse; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until the run ends.
- `run_done`  out  1  sticky; set when the core completes; cleared at next launch.
- `timed_out`  out  1  sticky; set on watchdog abort; cleared at next launch.
- `cycle_count`  out  CW  execution cycles of the last or current run.
- `core_reset`  out  1  drives the core's `reset`.
- `core_req`  out  1  drives the core's `req`.
- `core_done`  in  1  the core's `done`.

## Operation
- States:
  - IDLE: waits for `start`.
  - CRST: core held in reset.
  - REQ: one-cycle request to the core.
  - RUN: waits for `core_done`.
- IDLE:
  - `core_reset`=0, `core_req`=0, `busy`=0.
  - `start`=1 → CRST. On the same edge: clear `run_done`, `timed_out`, `cycle_count`; load the reset counter with `RST_CYCLES`-1.
- CRST:
  - `core_reset`=1, `busy`=1. The reset counter decrements each cycle.
  - When the reset counter is 0 → REQ.
- REQ:
  - `core_req`=1 for exactly one cycle; `cycle_count` increments.
  - → RUN.
- RUN:
  - On each edge with `core_done`=0, `cycle_count` increments, saturating.
  - `core_done`=1 → IDLE with `run_done`=1. `cycle_count` holds.
- Watchdog (`RUN_TIMEOUT_EN` only): in RUN, if `core_done`=0 and the incremented count equals `TIMEOUT` → IDLE with `timed_out`=1 and `cycle_count`=`TIMEOUT`.
- Boundary conditions:
  - `start` while `busy` is ignored; no re-launch and no count disturbance.
  - `core_done` outside RUN is ignored, including a stale `done` level during CRST or REQ.
  - If `core_done`=1 on the same edge the watchdog would fire, done wins: `run_done`=1, `timed_out`=0.
  - Counter saturation at 2^CW-1 does not end the run.
  - `run_done` and `timed_out` are never both 1.

## Timing
- All outputs are registered.
- Reset value of every output: `core_reset`=1 (core held in reset while the block is in reset), `core_req`=0, `busy`=0, `run_done`=0, `timed_out`=0, `cycle_count`=0. State is IDLE.
- Reset deassertion: `core_reset` falls on the first clock edge after `reset` drops.
- Launch timing, with `start` sampled at edge 0:
  - Edges 1 to `RST_CYCLES`: `core_reset`=1.
  - Edge `RST_CYCLES`+1: `core_req`=1.
  - Edge `RST_CYCLES`+2: RUN begins.
- Completion: `core_done` sampled high at edge N causes `run_done`=1 and `busy`=0 after edge N, which is 1 cycle latency.
- Count: `cycle_count` = 1 (the REQ cycle) + the number of RUN cycles with `core_done`=0.
- Reset mid-run: all outputs return to their reset values immediately (asynchronously), the core is reset, and the run is lost.

## Configuration
- `RUN_TIMEOUT_EN` defined: watchdog comparator compiled in; `timed_out` behaves as specified above.
- `RUN_TIMEOUT_EN` undefined: no comparator; `timed_out` is tied to 0; RUN waits indefinitely for `core_done`; `TIMEOUT` is unused.

## Structure
- Package `run_seq_pkg`:
  - `run_state_t` enum {IDLE, CRST, REQ, RUN}.
  - Default constants for `CW`, `RST_CYCLES` and `TIMEOUT`.
- Sub-module `sat_counter`: CW-bit counter with clear, enable, saturation and async reset. It is instantiated once for `cycle_count`. The small reset counter stays inline.

## Test plan
- Reset then idle: `reset` pulsed, no `start` → `core_reset` high during reset and 0 from the next edge; all other outputs 0; `core_req` never asserts.
- Normal run, `RST_CYCLES`=2: `start` at edge 0, `core_done` high at edge 8 → `core_reset` high at edges 1–2, `core_req` at edge 3, `run_done`=1, `busy`=0, `cycle_count`=5.
- Ignored inputs: `start` pulsed during RUN, and `core_done` held high through CRST/REQ then low → no relaunch, no early completion, count unaffected.
- Timeout with `RUN_TIMEOUT_EN`, `TIMEOUT`=16: `core_done` never rises → `timed_out`=1, `run_done`=0, `cycle_count`=16, `busy`=0.
- Done/timeout tie, same setup: `core_done` rises on the exact edge the count would reach 16 → `run_done`=1, `timed_out`=0.
- Back-to-back runs with mid-run reset: the second `start` clears the sticky flags; asserting `reset` during RUN sets all outputs to their reset values within the same cycle.

Source files
------------

// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
package run_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CRST = 2'd1,
    REQ  = 2'd2,
    RUN  = 2'd3
  } run_state_t;

  localparam int CW_DEF         = 16;
  localparam int RST_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF    = 4096;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear, count enable and saturation at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/run_sequencer.sv
// Launch controller for the core: reset pulse, one-cycle request, cycle count until done.
// Optional watchdog abort is compiled in when RUN_TIMEOUT_EN is defined.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int CW         = CW_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_run_done,
  output logic          o_timed_out,
  output logic [CW-1:0] o_cycle_count,
  output logic          o_core_reset,
  output logic          o_core_req,
  input  logic          i_core_done
);

  run_state_t   r_state;
  logic [3:0]   r_rst_cnt;
  logic         r_core_reset;
  logic         r_core_req;
  logic         r_busy;
  logic         r_run_done;
  logic         w_launch;
  logic         w_cnt_en;
  logic         w_wd_fire;
  logic [CW-1:0] w_count;

  assign w_launch = (r_state == IDLE) && i_start;
  assign w_cnt_en = (r_state == REQ) || ((r_state == RUN) && !i_core_done);

  sat_counter #(.W(CW)) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_launch),
    .i_en    (w_cnt_en),
    .o_count (w_count)
  );

`ifdef RUN_TIMEOUT_EN
  logic r_timed_out;

  // done has priority: the watchdog only fires on a RUN edge with done low
  assign w_wd_fire = (r_state == RUN) && !i_core_done &&
                     ((32'(w_count) + 32'd1) == 32'(TIMEOUT));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_timed_out <= 1'b0;
    end else if (w_launch) begin
      r_timed_out <= 1'b0;
    end else if (w_wd_fire) begin
      r_timed_out <= 1'b1;
    end
  end

  assign o_timed_out = r_timed_out;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = 32'(TIMEOUT);
  assign w_wd_fire        = 1'b0;
  assign o_timed_out      = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_rst_cnt    <= '0;
      r_core_reset <= 1'b1;
      r_core_req   <= 1'b0;
      r_busy       <= 1'b0;
      r_run_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_core_reset <= 1'b0;
          r_core_req   <= 1'b0;
          if (i_start) begin
            r_state      <= CRST;
            r_rst_cnt    <= 4'(RST_CYCLES - 1);
            r_core_reset <= 1'b1;
            r_busy       <= 1'b1;
            r_run_done   <= 1'b0;
          end
        end
        CRST: begin
          if (r_rst_cnt == 4'd0) begin
            r_state      <= REQ;
            r_core_reset <= 1'b0;
            r_core_req   <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt - 4'd1;
          end
        end
        REQ: begin
          r_state    <= RUN;
          r_core_req <= 1'b0;
        end
        RUN: begin
          if (i_core_done) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_run_done <= 1'b1;
          end else if (w_wd_fire) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_run_done    = r_run_done;
  assign o_cycle_count = w_count;
  assign o_core_reset  = r_core_reset;
  assign o_core_req    = r_core_req;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: vector table plus hand sequences for timeout, tie, saturation, reset.
// Watchdog checks follow RUN_TIMEOUT_EN the same way as the design.
module tb_run_sequencer;

  localparam int CW = 5;

  logic          clk;
  logic          reset;
  logic          start;
  logic          core_done;
  logic          busy;
  logic          run_done;
  logic          timed_out;
  logic [CW-1:0] cycle_count;
  logic          core_reset;
  logic          core_req;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic       start;
    logic       done;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl [23];

  run_sequencer #(
    .CW         (CW),
    .RST_CYCLES (2),
    .TIMEOUT    (16)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .o_busy        (busy),
    .o_run_done    (run_done),
    .o_timed_out   (timed_out),
    .o_cycle_count (cycle_count),
    .o_core_reset  (core_reset),
    .o_core_req    (core_req),
    .i_core_done   (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output bundle: {core_reset, core_req, busy, run_done, timed_out, cycle_count}
  function automatic logic [9:0] e(input bit cr, input bit req, input bit bz,
                                   input bit rd, input bit to, input int cnt);
    return {cr, req, bz, rd, to, 5'(cnt)};
  endfunction

  task automatic chk(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = {core_reset, core_req, busy, run_done, timed_out, cycle_count};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cr/req/busy/rd/to/cnt got %b required %b", name, act, exp);
    end else begin
      $display("ok   %s: cr/req/busy/rd/to/cnt = %b", name, act);
    end
  endtask

  task automatic step(input logic s, input logic d);
    @(negedge clk);
    start     = s;
    core_done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    core_done = 1'b0;

    // Normal run: start at edge 0, done at edge 8
    tbl[0]  = {1'b1, 1'b0, e(1, 0, 1, 0, 0, 0)};
    tbl[1]  = {1'b0, 1'b0, e(1, 0, 1, 0, 0, 0)};
    tbl[2]  = {1'b0, 1'b0, e(0, 1, 1, 0, 0, 0)};
    tbl[3]  = {1'b0, 1'b0, e(0, 0, 1, 0, 0, 1)};
    tbl[4]  = {1'b0, 1'b0, e(0, 0, 1, 0, 0, 2)};
    tbl[5]  = {1'b0, 1'b0, e(0, 0, 1, 0, 0, 3)};
    tbl[6]  = {1'b0, 1'b0, e(0, 0, 1, 0, 0, 4)};
    tbl[7]  = {1'b0, 1'b0, e(0, 0, 1, 0, 0, 5)};
    tbl[8]  = {1'b0, 1'b1, e(0, 0, 0, 1, 0, 5)};
    tbl[9]  = {1'b0, 1'b0, e(0, 0, 0, 1, 0, 5)};
    // Stale done through CRST/REQ, start during CRST and RUN
    tbl[10] = {1'b1, 1'b1, e(1, 0, 1, 0, 0, 0)};
    tbl[11] = {1'b1, 1'b1, e(1, 0, 1, 0, 0, 0)};
    tbl[12] = {1'b0, 1'b1, e(0, 1, 1, 0, 0, 0)};
    tbl[13] = {1'b0, 1'b1, e(0, 0, 1, 0, 0, 1)};
    tbl[14] = {1'b1, 1'b0, e(0, 0, 1, 0, 0, 2)};
    tbl[15] = {1'b1, 1'b0, e(0, 0, 1, 0, 0, 3)};
    tbl[16] = {1'b0, 1'b0, e(0, 0, 1, 0, 0, 4)};
    tbl[17] = {1'b0, 1'b1, e(0, 0, 0, 1, 0, 4)};
    // Done on the very first RUN edge
    tbl[18] = {1'b1, 1'b0, e(1, 0, 1, 0, 0, 0)};
    tbl[19] = {1'b0, 1'b0, e(1, 0, 1, 0, 0, 0)};
    tbl[20] = {1'b0, 1'b0, e(0, 1, 1, 0, 0, 0)};
    tbl[21] = {1'b0, 1'b0, e(0, 0, 1, 0, 0, 1)};
    tbl[22] = {1'b0, 1'b1, e(0, 0, 0, 1, 0, 1)};

    // Reset held, then released with no start
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("in_reset", e(1, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_release", e(0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1);
    chk("idle_done_ignored", e(0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].start, tbl[i].done);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Watchdog window: count reaches 15 at edge 17, 16 at edge 18
    step(1'b1, 1'b0);
    chk("wd_launch", e(1, 0, 1, 0, 0, 0));
    for (int i = 1; i <= 17; i++) step(1'b0, 1'b0);
    chk("wd_edge17", e(0, 0, 1, 0, 0, 15));
    step(1'b0, 1'b0);
`ifdef RUN_TIMEOUT_EN
    chk("wd_timeout", e(0, 0, 0, 0, 1, 16));
    step(1'b0, 1'b1);
    chk("wd_sticky", e(0, 0, 0, 0, 1, 16));
`else
    chk("wd_no_abort", e(0, 0, 1, 0, 0, 16));
    for (int i = 19; i <= 40; i++) step(1'b0, 1'b0);
    chk("saturated", e(0, 0, 1, 0, 0, 31));
    step(1'b0, 1'b1);
    chk("sat_done", e(0, 0, 0, 1, 0, 31));
`endif

    // Done on the same edge the watchdog would fire
    step(1'b1, 1'b0);
    chk("tie_launch_clears", e(1, 0, 1, 0, 0, 0));
    for (int i = 1; i <= 17; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("tie_done_wins", e(0, 0, 0, 1, 0, 15));

    // Asynchronous reset in the middle of RUN
    step(1'b1, 1'b0);
    chk("mid_launch", e(1, 0, 1, 0, 0, 0));
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0);
    chk("mid_running", e(0, 0, 1, 0, 0, 3));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_async_reset", e(1, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_release", e(0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1);
    chk("mid_run_lost", e(0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
